// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int c_DATA_W     = 16;
    localparam int c_ADDR_W     = 16;
    localparam int c_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_picker.sv
// ============================================================================
// Module      : mem_arb_picker
// Description : Combinational grant selection; load/store wins unless the
//               fetch-starvation guard (MEM_ARB_STARVE_GUARD_EN) forces fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = c_STARVE_MAX,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             i_ifReq,
    input  logic             i_dmReq,
    input  logic [CNT_W-1:0] i_starveCnt,
    output grant_t           o_grant
);

    logic w_starveHit;

`ifdef MEM_ARB_STARVE_GUARD_EN
    assign w_starveHit = i_ifReq && (i_starveCnt == CNT_W'(STARVE_MAX));
`else
    // Counter is tied off in the strict-priority build.
    logic w_unusedCnt;
    assign w_unusedCnt = ^i_starveCnt;
    assign w_starveHit = 1'b0;
`endif

    always_comb begin
        o_grant = GNT_IF;
        if (i_dmReq && !w_starveHit) begin
            o_grant = GNT_DM;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported data memory between fetch (read-only)
//               and load/store through an IDLE/ACCESS/RESP sequencer.
//               Optional fetch-starvation guard: MEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int ADDR_W     = c_ADDR_W,
    parameter int STARVE_MAX = c_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] readAddress,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

    state_t             r_state;
    state_t             w_nextState;
    grant_t             r_grant;
    grant_t             w_pick;
    logic               r_we;
    logic               w_anyReq;
    logic [c_CNT_W-1:0] w_starveCnt;
    logic [ADDR_W-1:0]  r_readAddress;
    logic [ADDR_W-1:0]  r_writeAddress;
    logic [DATA_W-1:0]  r_writeData;
    logic [DATA_W-1:0]  r_ifRdata;
    logic [DATA_W-1:0]  r_dmRdata;

    assign w_anyReq = if_req || dm_req;

    mem_arb_picker #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (c_CNT_W)
    ) u_picker (
        .i_ifReq     (if_req),
        .i_dmReq     (dm_req),
        .i_starveCnt (w_starveCnt),
        .o_grant     (w_pick)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [c_CNT_W-1:0] r_starveCnt;

    // Counts data grants that overtook a waiting fetch; the picker caps it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starveCnt <= '0;
        end else if (r_state == IDLE) begin
            if (!if_req || w_pick == GNT_IF) begin
                r_starveCnt <= '0;
            end else begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end
        end
    end

    assign w_starveCnt = r_starveCnt;
`else
    assign w_starveCnt = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        if_ack      = 1'b0;
        dm_ack      = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_anyReq) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                MemRead     = !r_we;
                MemWrite    = r_we;
                w_nextState = RESP;
            end
            RESP: begin
                if_ack      = (r_grant == GNT_IF);
                dm_ack      = (r_grant == GNT_DM);
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Memory address/data registers load on the IDLE->ACCESS edge so they are
    // valid for all of ACCESS and hold their value afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant        <= GNT_IF;
            r_we           <= 1'b0;
            r_readAddress  <= '0;
            r_writeAddress <= '0;
            r_writeData    <= '0;
            r_ifRdata      <= '0;
            r_dmRdata      <= '0;
        end else begin
            if (r_state == IDLE && w_anyReq) begin
                r_grant <= w_pick;
                if (w_pick == GNT_DM) begin
                    r_we <= dm_we;
                    if (dm_we) begin
                        r_writeAddress <= dm_addr;
                        r_writeData    <= dm_wdata;
                    end else begin
                        r_readAddress  <= dm_addr;
                    end
                end else begin
                    r_we          <= 1'b0;
                    r_readAddress <= if_addr;
                end
            end
            if (r_state == ACCESS && !r_we) begin
                if (r_grant == GNT_IF) begin
                    r_ifRdata <= readData;
                end else begin
                    r_dmRdata <= readData;
                end
            end
        end
    end

    assign readAddress  = r_readAddress;
    assign writeAddress = r_writeAddress;
    assign writeData    = r_writeData;
    assign if_rdata     = r_ifRdata;
    assign dm_rdata     = r_dmRdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomised self-checking bench for mem_port_arbiter with a
//               transaction-level reference model (honours MEM_ARB_STARVE_GUARD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit c_GUARD = 1'b1;
`else
    localparam bit c_GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ifReq, dmReq, dmWe;
    logic [ADDR_W-1:0] ifAddr, dmAddr;
    logic [DATA_W-1:0] dmWdata;
    logic              if_ack, dm_ack, MemRead, MemWrite, busy;
    logic [DATA_W-1:0] if_rdata, dm_rdata, writeData, readData;
    logic [ADDR_W-1:0] readAddress, writeAddress;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (ifReq),
        .if_addr      (ifAddr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .dm_req       (dmReq),
        .dm_we        (dmWe),
        .dm_addr      (dmAddr),
        .dm_wdata     (dmWdata),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .readAddress  (readAddress),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .readData     (readData),
        .busy         (busy)
    );

    // Physical memory attached to the arbiter; clears to zero on reset.
    logic [DATA_W-1:0] physMem [65536];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 65536; i++) physMem[i] <= '0;
        end else if (MemWrite) begin
            physMem[writeAddress] <= writeData;
        end
    end
    assign readData = physMem[readAddress];

    int testCount = 0;
    int failCount = 0;

    // Reference model: one access granted at a time, ACCESS on the cycle after
    // the grant edge, ack on the next, and the next grant three edges later.
    int          edgeNum, gEdge, starve;
    bit          gDm, gWe;
    logic [15:0] gAddr, gData;
    logic [15:0] expIfRdata, expDmRdata, expRdAddr, expWrAddr, expWrData;
    bit   [15:0] refMem [65536];

    byte ordQ[$];
    int  lastIfAck, lastDmAck, ifAckCnt, dmAckCnt;
    int  ifProb, dmProb;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        edgeNum = 0; gEdge = -100; starve = 0;
        gDm = 1'b0; gWe = 1'b0; gAddr = '0; gData = '0;
        expIfRdata = '0; expDmRdata = '0;
        expRdAddr = '0; expWrAddr = '0; expWrData = '0;
        for (int i = 0; i < 65536; i++) refMem[i] = '0;
    endtask

    task automatic modelStep();
        bit pickDm;
        edgeNum++;
        if (edgeNum == gEdge + 1 && !gWe) begin
            if (gDm) expDmRdata = gData;
            else     expIfRdata = gData;
        end
        if (edgeNum >= gEdge + 3) begin
            if (!ifReq) starve = 0;
            if (ifReq || dmReq) begin
                pickDm = dmReq && !(c_GUARD && ifReq && starve == STARVE_MAX);
                gEdge  = edgeNum;
                gDm    = pickDm;
                gWe    = pickDm && dmWe;
                gAddr  = pickDm ? dmAddr : ifAddr;
                if (gWe) begin
                    refMem[gAddr] = dmWdata;
                    expWrAddr     = gAddr;
                    expWrData     = dmWdata;
                end else begin
                    gData     = refMem[gAddr];
                    expRdAddr = gAddr;
                end
                if (!pickDm)    starve = 0;
                else if (ifReq) starve++;
            end
        end
    endtask

    task automatic checkOutputs();
        int ph;
        ph = edgeNum - gEdge;
        checkEq("busy",         busy,         (ph == 0 || ph == 1));
        checkEq("MemRead",      MemRead,      (ph == 0 && !gWe));
        checkEq("MemWrite",     MemWrite,     (ph == 0 && gWe));
        checkEq("if_ack",       if_ack,       (ph == 1 && !gDm));
        checkEq("dm_ack",       dm_ack,       (ph == 1 && gDm));
        checkEq("readAddress",  readAddress,  expRdAddr);
        checkEq("writeAddress", writeAddress, expWrAddr);
        checkEq("writeData",    writeData,    expWrData);
        checkEq("if_rdata",     if_rdata,     expIfRdata);
        checkEq("dm_rdata",     dm_rdata,     expDmRdata);
    endtask

    task automatic drive();
        if (ifReq && if_ack) begin
            ifReq = 1'b0;
        end else if (!ifReq && $urandom_range(0, 99) < ifProb) begin
            ifReq  = 1'b1;
            ifAddr = 16'($urandom_range(0, 15));
        end
        if (dmReq && dm_ack) begin
            dmReq = 1'b0;
        end else if (!dmReq && $urandom_range(0, 99) < dmProb) begin
            dmReq   = 1'b1;
            dmWe    = 1'($urandom_range(0, 1));
            dmAddr  = 16'($urandom_range(0, 15));
            dmWdata = 16'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutputs();
        if (if_ack) begin ordQ.push_back("I"); lastIfAck = edgeNum; ifAckCnt++; end
        if (dm_ack) begin ordQ.push_back("D"); lastDmAck = edgeNum; dmAckCnt++; end
        drive();
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((ifReq || dmReq || busy) && n < maxCycles);
        if (ifReq || dmReq || busy) checkEq("timeout_idle", 32'd0, 32'd1);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear immediately.
    task automatic doReset(input int dly);
        #(dly);
        reset = 1'b1; ifReq = 1'b0; dmReq = 1'b0;
        #1;
        resetModel();
        checkOutputs();
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int    n, startDm, startIf;
        string expOrd;
        reset = 1'b1; ifReq = 1'b0; dmReq = 1'b0; dmWe = 1'b0;
        ifAddr = '0; dmAddr = '0; dmWdata = '0;
        ifProb = 0; dmProb = 0;
        lastIfAck = 0; lastDmAck = 0; ifAckCnt = 0; dmAckCnt = 0;
        resetModel();
        @(negedge clk);
        checkOutputs();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) cycle();

        // Reset while idle
        doReset(2);

        // dm write 0x000A=0xFFFF, then fetch reads it back
        dmReq = 1'b1; dmWe = 1'b1; dmAddr = 16'h000A; dmWdata = 16'hFFFF;
        waitIdle(20);
        checkEq("wr_mem_A", physMem[16'h000A], 16'hFFFF);
        ifReq = 1'b1; ifAddr = 16'h000A;
        waitIdle(20);
        checkEq("if_rd_A", if_rdata, 16'hFFFF);

        // dm_rdata changes only on dm reads; if_rdata untouched by dm traffic
        dmReq = 1'b1; dmWe = 1'b1; dmAddr = 16'h0005; dmWdata = 16'hBEEF;
        waitIdle(20);
        checkEq("dm_rd_kept", dm_rdata, 16'h0000);
        dmReq = 1'b1; dmWe = 1'b0; dmAddr = 16'h0005;
        waitIdle(20);
        checkEq("dm_rd_5", dm_rdata, 16'hBEEF);
        checkEq("if_kept", if_rdata, 16'hFFFF);

        // Simultaneous requests: dm first, fetch three cycles later
        ifReq = 1'b1; ifAddr = 16'h0007;
        dmReq = 1'b1; dmWe = 1'b0; dmAddr = 16'h0002;
        waitIdle(30);
        checkEq("ack_gap", lastIfAck - lastDmAck, 32'd3);

        // Reset during ACCESS of a write aborts it
        dmReq = 1'b1; dmWe = 1'b1; dmAddr = 16'h0003; dmWdata = 16'h1234;
        n = 0;
        do begin cycle(); n++; end while (!MemWrite && n < 5);
        checkEq("abort_sawWrite", MemWrite, 1'b1);
        doReset(2);
        checkEq("abort_mem3", physMem[16'h0003], 16'h0000);
        ifReq = 1'b1; ifAddr = 16'h0003;
        waitIdle(20);
        checkEq("abort_rd3", if_rdata, 16'h0000);

        // Starvation scenario: fetch held, dm re-requests every IDLE
        repeat (3) cycle();
        ordQ.delete();
        ifReq = 1'b1; ifAddr = 16'h0009;
        dmReq = 1'b1; dmWe = 1'b0; dmAddr = 16'h0004;
        dmProb = 100;
`ifdef MEM_ARB_STARVE_GUARD_EN
        expOrd = "DDDDID";
        n = 0;
        while (ordQ.size() < 6 && n < 60) begin cycle(); n++; end
        checkEq("grant_cnt", ordQ.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < ordQ.size()) checkEq($sformatf("grant_%0d", i), ordQ[i], expOrd[i]);
        end
`else
        expOrd = "";
        startDm = dmAckCnt; startIf = ifAckCnt;
        n = 0;
        while (dmAckCnt - startDm < 20 && n < 100) begin cycle(); n++; end
        checkEq("dm_grants", dmAckCnt - startDm, 32'd20);
        checkEq("if_starved", ifAckCnt - startIf, 32'd0);
`endif
        dmProb = 0;
        waitIdle(40);

        // Random traffic against the model
        ifProb = 40; dmProb = 40;
        repeat (400) cycle();
        ifProb = 0; dmProb = 0;
        waitIdle(40);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
